// File: rtl/line_window_ctrl.sv
// Purpose: sequences line-buffer RAM reads/writes and tracks column, row and tap validity per frame.
// Latency: read slot 1 cycle after an accepted pixel, write slot 2 cycles after; line/frame pulses 1 cycle after dv falls.
// Backpressure: none; the pixel stream is consumed unconditionally, and excess pixels are dropped and flagged.
module line_window_ctrl #(
    parameter int SCREENWIDTH  = 1600,
    parameter int SCREENHEIGHT = 900,
    parameter int BUF_DEPTH    = 3,
    parameter int ADDR_W       = 11,
    parameter int ROW_W        = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dv_i,
    input  logic                 hs_i,
    input  logic                 vs_i,
    output logic                 mem_en_o,
    output logic                 mem_we_o,
    output logic [ADDR_W-1:0]    rd_addr_o,
    output logic [ADDR_W-1:0]    wr_addr_o,
    output logic [ADDR_W-1:0]    col_o,
    output logic [ROW_W-1:0]     row_o,
    output logic                 first_col_o,
    output logic                 last_col_o,
    output logic [BUF_DEPTH-1:0] row_valid_o,
    output logic                 line_done_o,
    output logic                 frame_done_o,
    output logic                 len_err_o,
    output logic                 height_err_o
);

    // One extra bit so the column counter can hold SCREENWIDTH itself (the saturation point).
    localparam int COL_W = ADDR_W + 1;
    localparam logic [COL_W-1:0] COL_MAX  = COL_W'(SCREENWIDTH);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(SCREENWIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(SCREENHEIGHT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VBLANK,
        ST_LINE,
        ST_HBLANK,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic             vs_q, dv_q, skip_q;
    logic             rd_vld_q, wr_vld_q;
    logic [COL_W-1:0] col_cnt_q;
    logic             vs_rise, dv_fall, accept, pix_ok, line_end, last_row;

    // Lines are delimited by dv alone; hs is accepted on the port but carries no control meaning here.
    logic unused_hs;
    assign unused_hs = hs_i;

    assign vs_rise  = vs_i & ~vs_q;
    assign dv_fall  = ~dv_i & dv_q;
    // A dv run that overlapped a frame start is skipped until dv drops and rises again.
    assign accept   = dv_i & ~skip_q & ~vs_rise &
                      ((state_q == ST_VBLANK) || (state_q == ST_HBLANK) || (state_q == ST_LINE));
    assign pix_ok   = accept & (col_cnt_q < COL_MAX);
    assign line_end = (state_q == ST_LINE) & dv_fall & ~vs_rise;
    assign last_row = (row_o == ROW_LAST);

    assign mem_we_o = wr_vld_q;
    assign mem_en_o = rd_vld_q | wr_vld_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; frame start overrides every other event.
    always_comb begin
        state_d = state_q;
        if (vs_rise) begin
            state_d = ST_VBLANK;
        end else begin
            case (state_q)
                ST_IDLE:   state_d = ST_IDLE;
                ST_VBLANK: if (accept) state_d = ST_LINE;
                ST_HBLANK: if (accept) state_d = ST_LINE;
                ST_LINE:   if (dv_fall) state_d = last_row ? ST_DONE : ST_HBLANK;
                ST_DONE:   state_d = ST_DONE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath: edge detect, column/row counters, read/write slots, tap validity and error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_q         <= 1'b0;
            dv_q         <= 1'b0;
            skip_q       <= 1'b0;
            rd_vld_q     <= 1'b0;
            wr_vld_q     <= 1'b0;
            col_cnt_q    <= '0;
            rd_addr_o    <= '0;
            wr_addr_o    <= '0;
            col_o        <= '0;
            row_o        <= '0;
            first_col_o  <= 1'b0;
            last_col_o   <= 1'b0;
            row_valid_o  <= '0;
            line_done_o  <= 1'b0;
            frame_done_o <= 1'b0;
            len_err_o    <= 1'b0;
            height_err_o <= 1'b0;
        end else begin
            vs_q         <= vs_i;
            dv_q         <= dv_i;
            line_done_o  <= 1'b0;
            frame_done_o <= 1'b0;
            first_col_o  <= 1'b0;
            last_col_o   <= 1'b0;
            rd_vld_q     <= 1'b0;
            // The write of a column trails its read by one cycle.
            wr_vld_q     <= rd_vld_q;
            if (rd_vld_q) wr_addr_o <= rd_addr_o;

            if (vs_rise)    skip_q <= dv_i;
            else if (!dv_i) skip_q <= 1'b0;

            if (vs_rise) begin
                col_cnt_q    <= '0;
                col_o        <= '0;
                row_o        <= '0;
                row_valid_o  <= '0;
                len_err_o    <= 1'b0;
                height_err_o <= 1'b0;
            end else begin
                if (accept) begin
                    if (pix_ok) begin
                        rd_vld_q    <= 1'b1;
                        rd_addr_o   <= col_cnt_q[ADDR_W-1:0];
                        col_o       <= col_cnt_q[ADDR_W-1:0];
                        first_col_o <= (col_cnt_q == '0);
                        last_col_o  <= (col_cnt_q == COL_LAST);
                        col_cnt_q   <= col_cnt_q + COL_W'(1);
                    end else begin
                        len_err_o   <= 1'b1;
                    end
                    if (row_o == '0) row_valid_o[0] <= 1'b1;
                end
                if (line_end) begin
                    line_done_o <= 1'b1;
                    col_cnt_q   <= '0;
                    row_valid_o <= {row_valid_o[BUF_DEPTH-2:0], 1'b1};
                    if (last_row) frame_done_o <= 1'b1;
                    else          row_o <= row_o + ROW_W'(1);
                end
                if ((state_q == ST_DONE) && dv_i) height_err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_line_window_ctrl.sv
// Directed bench for line_window_ctrl with a 4x3 frame and three taps.
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
// Each tick therefore shows the response to the inputs applied just before that edge.
module tb_line_window_ctrl;

    localparam int SW = 4;
    localparam int SH = 3;
    localparam int BD = 3;
    localparam int AW = 11;
    localparam int RW = 11;

    logic          clk = 1'b0;
    logic          rst;
    logic          dv_i, hs_i, vs_i;
    logic          mem_en_o, mem_we_o;
    logic [AW-1:0] rd_addr_o, wr_addr_o, col_o;
    logic [RW-1:0] row_o;
    logic          first_col_o, last_col_o;
    logic [BD-1:0] row_valid_o;
    logic          line_done_o, frame_done_o, len_err_o, height_err_o;

    int vectors     = 0;
    int miscompares = 0;

    line_window_ctrl #(
        .SCREENWIDTH (SW),
        .SCREENHEIGHT(SH),
        .BUF_DEPTH   (BD),
        .ADDR_W      (AW),
        .ROW_W       (RW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .dv_i        (dv_i),
        .hs_i        (hs_i),
        .vs_i        (vs_i),
        .mem_en_o    (mem_en_o),
        .mem_we_o    (mem_we_o),
        .rd_addr_o   (rd_addr_o),
        .wr_addr_o   (wr_addr_o),
        .col_o       (col_o),
        .row_o       (row_o),
        .first_col_o (first_col_o),
        .last_col_o  (last_col_o),
        .row_valid_o (row_valid_o),
        .line_done_o (line_done_o),
        .frame_done_o(frame_done_o),
        .len_err_o   (len_err_o),
        .height_err_o(height_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input logic dv, input logic vs);
        dv_i = dv;
        vs_i = vs;
        hs_i = ~dv;
        @(posedge clk);
        #1;
    endtask

    // n pixels, the falling-dv cycle, then two idle cycles; tallies what the outputs did.
    task automatic send_line(input int n, output int n_en, output int n_we,
                             output int n_done, output int n_frame, output int err_at);
        n_en = 0; n_we = 0; n_done = 0; n_frame = 0; err_at = 0;
        for (int i = 0; i < n + 3; i++) begin
            tick(i < n, 1'b0);
            if (mem_en_o)     n_en++;
            if (mem_we_o)     n_we++;
            if (line_done_o)  n_done++;
            if (frame_done_o) n_frame++;
            if (len_err_o && err_at == 0) err_at = i + 1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_en, n_we, n_done, n_frame, err_at;
        int acc_en, acc_done;

        // Reset state.
        rst = 1'b1; dv_i = 1'b0; vs_i = 1'b0; hs_i = 1'b0;
        tick(0, 0);
        tick(0, 0);
        chk("rst_mem_en", mem_en_o, 0);
        chk("rst_mem_we", mem_we_o, 0);
        chk("rst_row", row_o, 0);
        chk("rst_row_valid", row_valid_o, 0);
        chk("rst_col", col_o, 0);
        chk("rst_errs", {len_err_o, height_err_o, line_done_o, frame_done_o}, 0);
        rst = 1'b0;

        // Pixels before any frame start are ignored.
        acc_en = 0; acc_done = 0;
        for (int i = 0; i < 6; i++) begin
            tick(i < 3, 0);
            if (mem_en_o || mem_we_o) acc_en++;
            if (line_done_o)          acc_done++;
        end
        chk("idle_mem_activity", acc_en, 0);
        chk("idle_line_done", acc_done, 0);

        // Frame start, then one full line with per-cycle checks.
        tick(0, 1);
        tick(0, 0);
        for (int c = 0; c < SW; c++) begin
            tick(1, 0);
            chk("l0_rd_addr", rd_addr_o, c);
            chk("l0_col", col_o, c);
            chk("l0_mem_en", mem_en_o, 1);
            chk("l0_first", first_col_o, (c == 0));
            chk("l0_last", last_col_o, (c == SW - 1));
            chk("l0_mem_we", mem_we_o, (c > 0));
            if (c > 0) chk("l0_wr_addr", wr_addr_o, c - 1);
            chk("l0_row_valid0", row_valid_o, 3'b001);
        end
        tick(0, 0);
        chk("l0_tail_we", mem_we_o, 1);
        chk("l0_tail_wr_addr", wr_addr_o, SW - 1);
        chk("l0_tail_en", mem_en_o, 1);
        chk("l0_line_done", line_done_o, 1);
        chk("l0_row", row_o, 1);
        chk("l0_row_valid", row_valid_o, 3'b011);
        chk("l0_frame_done", frame_done_o, 0);
        tick(0, 0);
        chk("l0_idle_en", mem_en_o, 0);
        chk("l0_hold_rd", rd_addr_o, SW - 1);
        chk("l0_hold_wr", wr_addr_o, SW - 1);
        chk("l0_done_pulse", line_done_o, 0);

        // Rows 1 and 2 complete the frame.
        send_line(SW, n_en, n_we, n_done, n_frame, err_at);
        chk("l1_done_cnt", n_done, 1);
        chk("l1_frame_cnt", n_frame, 0);
        chk("l1_row", row_o, 2);
        chk("l1_row_valid", row_valid_o, 3'b111);
        send_line(SW, n_en, n_we, n_done, n_frame, err_at);
        chk("l2_we_cnt", n_we, SW);
        chk("l2_en_cnt", n_en, SW + 1);
        chk("l2_done_cnt", n_done, 1);
        chk("l2_frame_cnt", n_frame, 1);
        chk("l2_row", row_o, SH - 1);
        chk("l2_row_valid", row_valid_o, 3'b111);
        chk("l2_height_err", height_err_o, 0);

        // An extra line after the frame completed.
        send_line(SW, n_en, n_we, n_done, n_frame, err_at);
        chk("l3_we_cnt", n_we, 0);
        chk("l3_en_cnt", n_en, 0);
        chk("l3_done_cnt", n_done, 0);
        chk("l3_frame_cnt", n_frame, 0);
        chk("l3_height_err", height_err_o, 1);

        // Frame start clears the frame state.
        tick(0, 1);
        chk("vs_height_clr", height_err_o, 0);
        chk("vs_row_clr", row_o, 0);
        chk("vs_rv_clr", row_valid_o, 0);
        tick(0, 0);

        // Over-long line: six pixels into a four-pixel line.
        send_line(6, n_en, n_we, n_done, n_frame, err_at);
        chk("long_en_cnt", n_en, SW + 1);
        chk("long_we_cnt", n_we, SW);
        chk("long_err_at", err_at, 5);
        chk("long_len_err", len_err_o, 1);
        chk("long_done_cnt", n_done, 1);
        chk("long_row", row_o, 1);
        tick(0, 1);
        chk("vs_len_clr", len_err_o, 0);
        tick(0, 0);

        // Frame start arriving in the middle of a dv run.
        send_line(SW, n_en, n_we, n_done, n_frame, err_at);
        chk("mid_pre_row", row_o, 1);
        tick(1, 0);
        tick(1, 0);
        chk("mid_pre_col", col_o, 1);
        tick(1, 1);
        chk("mid_vs_row", row_o, 0);
        chk("mid_vs_rv", row_valid_o, 0);
        chk("mid_vs_first", first_col_o, 0);
        tick(1, 0);
        chk("mid_skip_en_a", mem_en_o, 0);
        tick(1, 0);
        chk("mid_skip_en_b", mem_en_o, 0);
        tick(0, 0);
        chk("mid_skip_done", line_done_o, 0);
        chk("mid_skip_row", row_o, 0);
        tick(1, 0);
        chk("mid_new_rd", rd_addr_o, 0);
        chk("mid_new_first", first_col_o, 1);
        chk("mid_new_en", mem_en_o, 1);
        chk("mid_new_rv", row_valid_o, 3'b001);
        tick(1, 0);
        tick(1, 0);
        tick(1, 0);
        chk("mid_new_last", last_col_o, 1);
        tick(0, 0);
        chk("mid_new_done", line_done_o, 1);
        chk("mid_new_row", row_o, 1);
        chk("mid_new_rv2", row_valid_o, 3'b011);
        tick(0, 0);

        // Reset pulse during column 2.
        tick(1, 0);
        tick(1, 0);
        rst = 1'b1;
        tick(1, 0);
        rst = 1'b0;
        chk("mrst_en_we", {mem_en_o, mem_we_o}, 0);
        chk("mrst_addrs", {rd_addr_o, wr_addr_o, col_o}, 0);
        chk("mrst_row", row_o, 0);
        chk("mrst_rv", row_valid_o, 0);
        chk("mrst_flags", {first_col_o, last_col_o, line_done_o, frame_done_o,
                           len_err_o, height_err_o}, 0);
        acc_en = 0; acc_done = 0;
        for (int i = 0; i < 6; i++) begin
            tick((i % 3) != 2, 0);
            if (mem_en_o)    acc_en++;
            if (line_done_o) acc_done++;
        end
        chk("mrst_ignored_en", acc_en, 0);
        chk("mrst_ignored_done", acc_done, 0);
        tick(0, 1);
        tick(0, 0);
        tick(1, 0);
        chk("mrst_resume_en", mem_en_o, 1);
        chk("mrst_resume_first", first_col_o, 1);
        chk("mrst_resume_rv", row_valid_o, 3'b001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
